irq_controller: RTL

Machine-mode interrupt controller for the single-cycle RISC-V core. It sits between the peripheral interrupt lines, the CSR file (mie), and the core's trap logic. It arbitrates up to N enabled requests by fixed priority, raises a single trap request with the matching mcause value, and blocks nesting until the handler's mret. It also tracks synchronous exceptions, so that an mret is attributed to the correct trap and acknowledges the serviced device.

---
 rtl/riscv_pkg.sv | 21 ++
 rtl/irq_prio_enc.sv | 24 ++
 rtl/irq_controller.sv | 133 +++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared trap-path types and constants for the single-cycle RISC-V core.
// Pure declarations: no latency, no flow control.
package riscv_pkg;

   typedef enum logic [1:0] {
      IRQ_IDLE = 2'd0,
      IRQ_ARM  = 2'd1,
      IRQ_BUSY = 2'd2
   } irq_state_t;

   localparam int IRQ_CAUSE_BASE = 16;
   localparam int MCAUSE_INT_BIT = 31;

   function automatic logic [31:0] irq_mcause(input int base, input int idx);
      logic [31:0] c;
      c = 32'(base + idx);
      c[MCAUSE_INT_BIT] = 1'b1;
      return c;
   endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// Lowest-index-first priority encoder over the pending interrupt vector.
// Purely combinational (zero latency); no flow control.
module irq_prio_enc #(
   parameter int N    = 16,
   parameter int IDXW = 4
) (
   input  logic [N-1:0]    req,
   output logic [IDXW-1:0] idx,
   output logic            vld
);

   // Scanning downward leaves the lowest set bit as the final winner.
   always_comb begin
      idx = '0;
      vld = 1'b0;
      for (int k = N - 1; k >= 0; k--) begin
         if (req[k]) begin
            idx = IDXW'(k);
            vld = 1'b1;
         end
      end
   end

endmodule

// File: rtl/irq_controller.sv
// Machine-mode interrupt controller: fixed-priority arbitration, trap request, mret acknowledge.
// 1-cycle request-to-irq_o; stall_i holds entry/return commit. IRQ_PENDING_LATCH_EN adds edge-latched pending bits.
module irq_controller
   import riscv_pkg::*;
#(
   parameter int N_IRQ      = 16,
   parameter int CAUSE_BASE = IRQ_CAUSE_BASE
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             stall_i,
   input  logic             exception_i,
   input  logic             mret_i,
   input  logic [N_IRQ-1:0] mie_i,
   input  logic [N_IRQ-1:0] irq_req_i,
   output logic             irq_o,
   output logic [31:0]      irq_cause_o,
   output logic [N_IRQ-1:0] irq_ret_o
);

   localparam int IDXW = (N_IRQ > 1) ? $clog2(N_IRQ) : 1;

   irq_state_t       state;
   logic             exc_h;
   logic [IDXW-1:0]  idx;
   logic             irq_q;
   logic [N_IRQ-1:0] ret_q;
   logic [N_IRQ-1:0] pend_vec;
   logic [N_IRQ-1:0] cand_vec;
   logic [N_IRQ-1:0] ack_vec;
   logic [IDXW-1:0]  enc_idx;
   logic             enc_vld;
   logic             commit_ok;

`ifdef IRQ_PENDING_LATCH_EN
   logic [N_IRQ-1:0] req_q;
   logic [N_IRQ-1:0] pend_q;
   logic [N_IRQ-1:0] rise_vec;

   assign rise_vec = irq_req_i & ~req_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         req_q  <= '0;
         pend_q <= '0;
      end else begin
         req_q  <= irq_req_i;
         pend_q <= (pend_q & ~ret_q) | rise_vec;
      end
   end

   // A fresh edge is visible in the same cycle so latency matches the level-sensitive build.
   assign pend_vec = (pend_q | rise_vec) & mie_i;
`else
   assign pend_vec = irq_req_i & mie_i;
`endif

   // The line being acknowledged is still asserted this cycle; don't retake it on the ack.
   assign cand_vec  = pend_vec & ~ret_q;
   assign commit_ok = ~stall_i;

   irq_prio_enc #(
      .N    (N_IRQ),
      .IDXW (IDXW)
   ) u_prio_enc (
      .req (cand_vec),
      .idx (enc_idx),
      .vld (enc_vld)
   );

   always_comb begin
      ack_vec = '0;
      for (int k = 0; k < N_IRQ; k++) begin
         ack_vec[k] = (idx == IDXW'(k));
      end
   end

   // Exception-in-progress flag: the next committed mret belongs to the exception handler.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         exc_h <= 1'b0;
      end else if (exception_i && commit_ok) begin
         exc_h <= 1'b1;
      end else if (mret_i && commit_ok && exc_h) begin
         exc_h <= 1'b0;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state <= IRQ_IDLE;
         idx   <= '0;
         irq_q <= 1'b0;
         ret_q <= '0;
      end else begin
         ret_q <= '0;
         case (state)
            IRQ_IDLE: begin
               if (enc_vld && !exc_h && !exception_i) begin
                  idx   <= enc_idx;
                  irq_q <= 1'b1;
                  state <= IRQ_ARM;
               end
            end
            IRQ_ARM: begin
               if (exception_i) begin
                  irq_q <= 1'b0;
                  state <= IRQ_IDLE;
               end else if (commit_ok) begin
                  irq_q <= 1'b0;
                  state <= IRQ_BUSY;
               end
            end
            IRQ_BUSY: begin
               if (mret_i && commit_ok && !exc_h) begin
                  ret_q <= ack_vec;
                  state <= IRQ_IDLE;
               end
            end
            default: begin
               irq_q <= 1'b0;
               state <= IRQ_IDLE;
            end
         endcase
      end
   end

   // An exception in ARM pre-empts the entry within the same cycle.
   assign irq_o       = irq_q & ~exception_i;
   assign irq_cause_o = irq_o ? irq_mcause(CAUSE_BASE, int'(idx)) : 32'd0;
   assign irq_ret_o   = ret_q;

endmodule
